serial_sub: RTL and testbench

- Bit-serial two's-complement subtractor: computes diff = x - y, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Inverse operation of the team's 4-bit ripple adder, sharing its operand and result conventions.
- Sits in the arithmetic datapath where area matters more than latency.
- A start/busy/done handshake launches each operation and returns the result.

---
 rtl/serial_sub.sv | 162 ++++++++++++++++
 tb/tb_serial_sub.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor, diff = x - y.
// One bit is processed per clock, LSB first. A single full-subtractor cell
// feeds a registered borrow. A start/busy/done handshake launches each
// operation. An operation takes WIDTH+2 cycles from the accepting edge to
// the return to IDLE.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..16), default 4
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   start   in   launch request, sampled only in IDLE
//   x       in   minuend, captured on the accepting edge
//   y       in   subtrahend, captured on the accepting edge
//   busy    out  high while bits are being processed (SHIFT)
//   done    out  one-cycle result-valid pulse (DONE)
//   diff    out  (x - y) mod 2^WIDTH, held until the next result
//   borrow  out  final borrow, 1 iff x < y unsigned, held with diff
//   ovf     out  signed overflow, present only with SERIAL_SUB_OVF_EN
//
// Build option:
//   SERIAL_SUB_OVF_EN  adds the registered ovf output
//
// state | meaning
// IDLE  | waiting for start, operands not yet captured
// SHIFT | one result bit per edge, counter selects bit index
// DONE  | result registered, done pulse for one cycle

module serial_sub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             borrow,
   output logic             ovf
`else
   output logic             borrow
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             d_bit, b_next;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // Full-subtractor cell on the current LSBs of the operand shift registers
   assign d_bit  = x_q[0] ^ y_q[0] ^ b_q;
   assign b_next = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & b_q);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      res_d    = res_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = x;
               y_d     = y;
               res_d   = '0;
               b_d     = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Result bits enter at the MSB so after WIDTH shifts bit 0 holds d_0
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = d_bit;
            x_d              = x_q >> 1;
            y_d              = y_q >> 1;
            b_d              = b_next;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               diff_d   = res_d;
               borrow_d = b_next;
`ifdef SERIAL_SUB_OVF_EN
               // On the last bit x_q[0]/y_q[0] are the operand sign bits
               ovf_d    = (x_q[0] != y_q[0]) && (d_bit != x_q[0]);
`endif
               cnt_d    = '0;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         res_q    <= '0;
         b_q      <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         res_q    <= res_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed testbench for serial_sub (WIDTH = 4). Inputs are driven and
// outputs sampled on the falling clock edge.

module tb_serial_sub;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   serial_sub #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .x      (x),
      .y      (y),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
      .borrow (borrow),
      .ovf    (ovf)
`else
      .borrow (borrow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; x = '0; y = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
      n_vec++; if (diff !== 4'h0) begin n_err++; $display("FAIL reset_diff: got %h expected 0", diff); end
      n_vec++; if (borrow !== 1'b0) begin n_err++; $display("FAIL reset_borrow: got %b expected 0", borrow); end
`ifdef SERIAL_SUB_OVF_EN
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
   endtask

   // 9 - 3: busy in cycles N+1..N+4, done in N+5, back to idle in N+6
   task automatic test_latency();
      x = 4'd9; y = 4'd3; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
         n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL lat_shift_c%0d: got busy=%b done=%b expected busy=1 done=0", c, busy, done);
         end
      end
      @(negedge clk);
      n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL lat_done: got busy=%b done=%b expected busy=0 done=1", busy, done);
      end
      n_vec++; if (diff !== 4'd6 || borrow !== 1'b0) begin
         n_err++; $display("FAIL lat_result: got diff=%h borrow=%b expected diff=6 borrow=0", diff, borrow);
      end
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL lat_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_arith();
      logic [WIDTH-1:0] tx [7] = '{4'd3, 4'd0, 4'd7, 4'd15, 4'd0, 4'd8, 4'd10};
      logic [WIDTH-1:0] ty [7] = '{4'd9, 4'd1, 4'd7, 4'd0, 4'd15, 4'd1, 4'd4};
      logic [WIDTH-1:0] td [7] = '{4'hA, 4'hF, 4'h0, 4'hF, 4'h1, 4'h7, 4'h6};
      logic             tb [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         int k;
         bit got;
         x = tx[i]; y = ty[i]; start = 1'b1;
         k = 0; got = 1'b0;
         while (!got && k < 12) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (done === 1'b1) got = 1'b1;
         end
         n_vec++; if (!got || k != WIDTH + 1) begin
            n_err++; $display("FAIL arith%0d_latency: got done at cycle %0d (seen=%0b) expected %0d", i, k, got, WIDTH + 1);
         end
         n_vec++; if (diff !== td[i] || borrow !== tb[i]) begin
            n_err++; $display("FAIL arith%0d_%0d_minus_%0d: got diff=%h borrow=%b expected diff=%h borrow=%b",
                              i, tx[i], ty[i], diff, borrow, td[i], tb[i]);
         end
         @(negedge clk);
      end
   endtask

   // start held high: results in cycles N+5 and N+11; inputs changed mid-SHIFT
   task automatic test_back_to_back();
      int done_cnt;
      x = 4'd5; y = 4'd2; start = 1'b1;
      done_cnt = 0;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 7) begin x = 4'd15; y = 4'd15; end
         if (c == 11) start = 1'b0;
         if (c == 5 || c == 11) begin
            n_vec++; if (done !== 1'b1 || diff !== 4'd3 || borrow !== 1'b0) begin
               n_err++; $display("FAIL b2b_done_c%0d: got done=%b diff=%h borrow=%b expected done=1 diff=3 borrow=0",
                                 c, done, diff, borrow);
            end
         end else if (done === 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL b2b_extra_done: got done=1 at cycle %0d expected 0", c);
         end
         if (done === 1'b1) done_cnt++;
      end
      n_vec++; if (done_cnt != 2 || busy !== 1'b0) begin
         n_err++; $display("FAIL b2b_count: got %0d results busy=%b expected 2 results busy=0", done_cnt, busy);
      end
   endtask

   // reset in the 2nd SHIFT cycle of 12 - 5 aborts with no done
   task automatic test_reset_abort();
      bit seen;
      x = 4'd12; y = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_pre: got %b expected 1", busy); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++; if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'h0 || borrow !== 1'b0) begin
         n_err++; $display("FAIL abort_state: got busy=%b done=%b diff=%h borrow=%b expected 0 0 0 0",
                           busy, done, diff, borrow);
      end
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      n_vec++; if (seen) begin n_err++; $display("FAIL abort_no_done: got activity=1 expected 0"); end
   endtask

   // diff = 6 from 9 - 3 stays visible during 3 - 9 SHIFT cycles
   task automatic test_hold();
      x = 4'd9; y = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++; if (diff !== 4'd6) begin n_err++; $display("FAIL hold_setup: got %h expected 6", diff); end
      x = 4'd3; y = 4'd9; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
         x = 4'd0; y = 4'd0;
         n_vec++; if (diff !== 4'd6 || borrow !== 1'b0) begin
            n_err++; $display("FAIL hold_c%0d: got diff=%h borrow=%b expected diff=6 borrow=0", c, diff, borrow);
         end
      end
      @(negedge clk);
      n_vec++; if (done !== 1'b1 || diff !== 4'hA || borrow !== 1'b1) begin
         n_err++; $display("FAIL hold_update: got done=%b diff=%h borrow=%b expected 1 a 1", done, diff, borrow);
      end
      @(negedge clk);
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      logic [WIDTH-1:0] tx [4] = '{4'h8, 4'h2, 4'h7, 4'h0};
      logic [WIDTH-1:0] ty [4] = '{4'h1, 4'h1, 4'hF, 4'h1};
      logic [WIDTH-1:0] td [4] = '{4'h7, 4'h1, 4'h8, 4'hF};
      logic             to [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         x = tx[i]; y = ty[i]; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (4) @(negedge clk);
         n_vec++; if (done !== 1'b1 || diff !== td[i] || ovf !== to[i]) begin
            n_err++; $display("FAIL ovf%0d: got done=%b diff=%h ovf=%b expected done=1 diff=%h ovf=%b",
                              i, done, diff, ovf, td[i], to[i]);
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; x = '0; y = '0;
      test_reset();
      test_latency();
      test_arith();
      test_back_to_back();
      test_reset_abort();
      test_hold();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
